// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM states, line-level bit constants, parity
// encoding and default widths. The RX side uses the same bit and parity constants.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
    localparam int unsigned DEFAULT_PRESCALE_WIDTH = 6;

    // Line levels of the framing bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Par_Typ encoding
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side and serial-side signals of the UART transmitter.
// master: the byte source (drives data/config, observes TX_OUT/Busy).
// slave:  the uart_tx block itself.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
);

    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      Par_En;
    logic                      Par_Typ;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output Prescale,
        output Par_En,
        output Par_Typ,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  Prescale,
        input  Par_En,
        input  Par_Typ,
        output TX_OUT,
        output Busy
    );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter. Counts 0..prescale-1 while enabled
// and strobes bit_done on the last clock of each bit. A prescale of 0 acts as 1.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done
);

    logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRESCALE_WIDTH-1:0] last_cnt;

    // Terminal count and next count; idle counter parks at zero
    always_comb begin
        last_cnt    = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
        bit_done    = enable && (presc_cnt_q == last_cnt);
        presc_cnt_d = presc_cnt_q + PRESCALE_WIDTH'(1);
        if (!enable || bit_done) begin
            presc_cnt_d = '0;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// stop bit. Each bit lasts Prescale clocks. Data and configuration are latched
// on acceptance, so mid-frame input changes do not affect the frame in flight.
// Build option UART_TX_STOP2_EN: send two stop bits instead of one.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);

    localparam int unsigned BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    tx_state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic                      tx_out_q, tx_out_d;
    logic                      busy_q, busy_d;
`ifdef UART_TX_STOP2_EN
    logic                      stop_cnt_q, stop_cnt_d;
`endif

    logic timer_en;
    logic bit_done;
    logic parity_bit;

    assign timer_en = (state_q != StIdle);

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .enable   (timer_en),
        .prescale (presc_q),
        .bit_done (bit_done)
    );

    // Parity over the latched byte; even parity makes the total count of ones even
    assign parity_bit = (par_typ_q == PAR_EVEN) ? (^data_q) : ~(^data_q);

    // Next-state logic plus registered-output precompute
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_STOP2_EN
        stop_cnt_d = stop_cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.Data_Valid) begin
                    state_d   = StStart;
                    data_d    = bus.P_DATA;
                    presc_d   = bus.Prescale;
                    par_en_d  = bus.Par_En;
                    par_typ_d = bus.Par_Typ;
                    bit_cnt_d = '0;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (bit_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_done) begin
`ifdef UART_TX_STOP2_EN
                    if (!stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        state_d    = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs follow the state being entered so they change on the same edge
        tx_out_d = STOP_BIT;
        unique case (state_d)
            StStart:  tx_out_d = START_BIT;
            StData:   tx_out_d = data_d[bit_cnt_d];
            StParity: tx_out_d = parity_bit;
            default:  tx_out_d = STOP_BIT;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State, latched frame parameters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            data_q    <= '0;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            bit_cnt_q <= '0;
            tx_out_q  <= STOP_BIT;
            busy_q    <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop_cnt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            bit_cnt_q <= bit_cnt_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
`ifdef UART_TX_STOP2_EN
            stop_cnt_q <= stop_cnt_d;
`endif
        end
    end

    assign bus.TX_OUT = tx_out_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a per-cycle waveform model (queue of expected line levels
// built from the frame rules at acceptance) plus directed frames with
// hand-computed bit patterns, frame lengths and inter-frame gap.
module tb_uart_tx;
    import uart_pkg::*;

`ifdef UART_TX_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

    uart_tx #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    logic exp_q[$];
    logic cur_tx   = 1'b1;
    logic cur_busy = 1'b0;
    int   shown    = 0;

    function automatic void build_frame(logic [7:0] d, logic pe, logic pt, logic [5:0] ps);
        int   p;
        logic bits[$];
        p = (ps == 6'd0) ? 1 : int'(ps);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(1'((($countones(d) + (pt ? 1 : 0)) % 2)));
        for (int i = 0; i < STOP_BITS; i++) bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[i]) begin
            for (int k = 0; k < p; k++) exp_q.push_back(bits[i]);
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur_tx   = 1'b1;
            cur_busy = 1'b0;
        end else if (!cur_busy && bus.Data_Valid) begin
            build_frame(bus.P_DATA, bus.Par_En, bus.Par_Typ, bus.Prescale);
            cur_tx   = exp_q.pop_front();
            cur_busy = 1'b1;
        end else if (exp_q.size() > 0) begin
            cur_tx   = exp_q.pop_front();
            cur_busy = 1'b1;
        end else begin
            cur_tx   = 1'b1;
            cur_busy = 1'b0;
        end
        #1;
        checks++;
        if (bus.TX_OUT !== cur_tx || bus.Busy !== cur_busy) begin
            errors++;
            if (shown < 20)
                $display("FAIL cycle_model t=%0t TX_OUT=%b Busy=%b expected TX_OUT=%b Busy=%b",
                         $time, bus.TX_OUT, bus.Busy, cur_tx, cur_busy);
            shown++;
        end
    end

    // ---------------- frame monitor ----------------
    logic hist[256];
    int   hidx = 0;
    int   frame_len = 0;
    int   frames_started = 0;
    int   frames_done = 0;
    int   idle_cnt = 0;
    int   last_gap = -1;
    logic prev_busy = 1'b0;

    always @(posedge clk) begin
        #1;
        if (bus.Busy === 1'b1) begin
            if (!prev_busy) begin
                hidx = 0;
                frames_started++;
                last_gap = idle_cnt;
            end
            if (hidx < 256) hist[hidx] = bus.TX_OUT;
            hidx++;
        end else begin
            if (prev_busy) begin
                frame_len = hidx;
                frames_done++;
                idle_cnt = 0;
            end
            idle_cnt++;
        end
        prev_busy = (bus.Busy === 1'b1);
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        @(negedge clk);
        bus.P_DATA     = d;
        bus.Par_En     = pe;
        bus.Par_Typ    = pt;
        bus.Prescale   = ps;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames_done < target) begin
            checks++;
            errors++;
            $display("FAIL %s: frame end not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_started(input int target, input int budget, input string name);
        int n = 0;
        while (frames_started < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames_started < target) begin
            checks++;
            errors++;
            $display("FAIL %s: frame start not seen within %0d cycles", name, budget);
        end
    endtask

    // Sample each bit in its middle and compare with a literal frame pattern
    task automatic check_bits(input string name, input logic [11:0] exp, input int nbits,
                              input int p);
        for (int i = 0; i < nbits; i++)
            check($sformatf("%s_bit%0d", name, i), {31'b0, hist[i*p + p/2]}, {31'b0, exp[i]});
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int base_done;
        int base_st;
        int ones;

        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b0;
        bus.Prescale   = 6'd8;
        bus.Par_En     = 1'b0;
        bus.Par_Typ    = 1'b0;
        rst            = 1'b1;
        tick(3);
        check("reset_tx", {31'b0, bus.TX_OUT}, 1);
        check("reset_busy", {31'b0, bus.Busy}, 0);
        rst = 1'b0;
        tick(2);

        // 0xA5, even parity, prescale 8
        base_done = frames_done;
        send(8'hA5, 1'b1, 1'b0, 6'd8);
        wait_done(base_done + 1, 400, "a5_done");
        check("a5_len", frame_len, 88 + 8 * (STOP_BITS - 1));
        check_bits("a5", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8);

        // 0x3C, odd parity -> parity bit 1
        base_done = frames_done;
        send(8'h3C, 1'b1, 1'b1, 6'd8);
        wait_done(base_done + 1, 400, "3c_done");
        check("3c_len", frame_len, 88 + 8 * (STOP_BITS - 1));
        check("3c_parity", {31'b0, hist[9*8 + 4]}, 1);
        check_bits("3c", {1'b1, 1'b1, 8'h3C, 1'b0}, 11, 8);

        // 0xFF, no parity, prescale 16
        base_done = frames_done;
        send(8'hFF, 1'b0, 1'b0, 6'd16);
        wait_done(base_done + 1, 600, "ff_done");
        check("ff_len", frame_len, 160 + 16 * (STOP_BITS - 1));
        ones = 0;
        for (int i = 0; i < 16; i++) if (hist[i] !== 1'b0) ones++;
        check("ff_start_low", ones, 0);
        ones = 0;
        for (int i = 16; i < 160; i++) if (hist[i] === 1'b1) ones++;
        check("ff_high_run", ones, 144);

        // 0x55 frame disturbed mid-data by a new request and a Par_Typ toggle
        base_done = frames_done;
        base_st   = frames_started;
        send(8'h55, 1'b1, 1'b0, 6'd8);
        tick(30);
        bus.P_DATA     = 8'h00;
        bus.Par_Typ    = 1'b1;
        bus.Data_Valid = 1'b1;
        tick(1);
        bus.Data_Valid = 1'b0;
        wait_done(base_done + 1, 400, "55_done");
        check("55_len", frame_len, 88 + 8 * (STOP_BITS - 1));
        check_bits("55", {1'b1, 1'b0, 8'h55, 1'b0}, 11, 8);
        tick(40);
        check("55_no_second", frames_started, base_st + 1);
        check("55_idle_busy", {31'b0, bus.Busy}, 0);
        bus.Par_Typ = 1'b0;

        // Reset during data bit 3 (together with Data_Valid), then a 0x81 frame
        base_st = frames_started;
        send(8'hF0, 1'b0, 1'b0, 6'd8);
        tick(35);
        rst            = 1'b1;
        bus.Data_Valid = 1'b1;
        tick(1);
        rst            = 1'b0;
        bus.Data_Valid = 1'b0;
        check("rst_mid_tx", {31'b0, bus.TX_OUT}, 1);
        check("rst_mid_busy", {31'b0, bus.Busy}, 0);
        tick(3);
        check("rst_no_accept", frames_started, base_st + 1);
        base_done = frames_done;
        send(8'h81, 1'b0, 1'b0, 6'd8);
        wait_done(base_done + 1, 400, "81_done");
        check("81_len", frame_len, 80 + 8 * (STOP_BITS - 1));
        check_bits("81", {2'b00, 1'b1, 8'h81, 1'b0}, 10, 8);

        // Data_Valid held high: 0x12 then 0x34 back to back
        base_done = frames_done;
        base_st   = frames_started;
        @(negedge clk);
        bus.P_DATA     = 8'h12;
        bus.Par_En     = 1'b0;
        bus.Prescale   = 6'd8;
        bus.Data_Valid = 1'b1;
        wait_started(base_st + 1, 20, "b2b_first_start");
        bus.P_DATA = 8'h34;
        wait_done(base_done + 1, 400, "b2b_first_done");
        check("b2b_first_len", frame_len, 80 + 8 * (STOP_BITS - 1));
        check_bits("b2b_12", {2'b00, 1'b1, 8'h12, 1'b0}, 10, 8);
        wait_started(base_st + 2, 20, "b2b_second_start");
        bus.Data_Valid = 1'b0;
        check("b2b_gap", last_gap, 1);
        wait_done(base_done + 2, 400, "b2b_second_done");
        check("b2b_second_len", frame_len, 80 + 8 * (STOP_BITS - 1));
        check_bits("b2b_34", {2'b00, 1'b1, 8'h34, 1'b0}, 10, 8);
        tick(20);
        check("b2b_no_third", frames_started, base_st + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
